// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// memory word width and the header count range check.
package boot_loader_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        RUN,
        ERROR
    } ld_state_e;

    // A header count larger than the memory depth can never be honoured.
    function automatic logic count_too_big(input logic [WORD_W-1:0] cnt,
                                           input int unsigned       addr_w);
        return 32'(cnt) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/boot_loader_mem_port_mux.sv
// Memory write-port arbiter: the loader owns the port until the CPU is
// released, after which CPU writes pass straight through.
module boot_loader_mem_port_mux
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              sel_cpu_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [WORD_W-1:0] ld_wdata_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_wdata_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o
);

    always_comb begin
        if (sel_cpu_i) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else begin
            mem_we_o    = ld_we_i;
            mem_addr_o  = ld_addr_i;
            mem_wdata_o = ld_wdata_i;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: takes a length-prefixed big-endian byte stream, writes it to
// memory from word 0, then releases the CPU and hands it the write port.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              cpu_we,
    input  logic [14:0]       cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_error
);

    ld_state_e         state_q;
    logic [ADDR_W:0]   addr_q;
    logic [WORD_W-1:0] count_q;
    logic [WORD_W-1:0] word_q;
    logic              rx_ready_q;
    logic              ld_we_q;
    logic              cpu_run_q;
    logic              load_done_q;
    logic              load_error_q;

    logic              xfer;
    logic [WORD_W-1:0] count_d;
    logic              unused_addr_bits;

    assign xfer    = rx_valid && rx_ready_q;
    assign count_d = {count_q[WORD_W-1:8], rx_data};

    // The address counter carries one spare bit so a full-depth load never
    // wraps; that bit and the CPU's upper address bits never reach memory.
    assign unused_addr_bits = ^{addr_q[ADDR_W], cpu_addr[14:ADDR_W]};

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CNT_HI;
            addr_q       <= '0;
            count_q      <= '0;
            word_q       <= '0;
            rx_ready_q   <= 1'b1;
            ld_we_q      <= 1'b0;
            cpu_run_q    <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                CNT_HI: begin
                    if (xfer) begin
                        count_q[WORD_W-1:8] <= rx_data;
                        state_q             <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (xfer) begin
                        count_q <= count_d;
                        if (count_d == '0) begin
                            state_q     <= RUN;
                            rx_ready_q  <= 1'b0;
                            cpu_run_q   <= 1'b1;
                            load_done_q <= 1'b1;
                        end else if (count_too_big(count_d, ADDR_W)) begin
                            state_q      <= ERROR;
                            rx_ready_q   <= 1'b0;
                            load_error_q <= 1'b1;
                        end else begin
                            state_q <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        word_q[WORD_W-1:8] <= rx_data;
                        state_q            <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        word_q[7:0] <= rx_data;
                        state_q     <= WRITE;
                        rx_ready_q  <= 1'b0;
                        ld_we_q     <= 1'b1;
                    end
                end
                WRITE: begin
                    ld_we_q <= 1'b0;
                    addr_q  <= addr_q + 1'b1;
                    count_q <= count_q - 1'b1;
                    if (count_q == 16'd1) begin
                        state_q     <= RUN;
                        cpu_run_q   <= 1'b1;
                        load_done_q <= 1'b1;
                    end else begin
                        state_q    <= DATA_HI;
                        rx_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                ERROR: begin
                    state_q <= ERROR;
                end
                default: begin
                    state_q      <= ERROR;
                    rx_ready_q   <= 1'b0;
                    ld_we_q      <= 1'b0;
                    cpu_run_q    <= 1'b0;
                    load_error_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign cpu_run    = cpu_run_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

    boot_loader_mem_port_mux #(
        .ADDR_W (ADDR_W)
    ) u_mem_port_mux (
        .sel_cpu_i   (state_q == RUN),
        .ld_we_i     (ld_we_q),
        .ld_addr_i   (addr_q[ADDR_W-1:0]),
        .ld_wdata_i  (word_q),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr[ADDR_W-1:0]),
        .cpu_wdata_i (cpu_wdata),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata)
    );

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued by the
// stimulus and popped by an independent monitor whenever mem_we is seen.
module tb_boot_loader;

    localparam int ADDR_W = 7;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_ready;
    logic              cpu_we = 1'b0;
    logic [14:0]       cpu_addr = '0;
    logic [15:0]       cpu_wdata = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_run;
    logic              load_done;
    logic              load_error;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    logic [15:0] mem_model [0:(1<<ADDR_W)-1];

    boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // Stand-in for the external word memory.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after each falling edge.
    always begin
        @(negedge clk);
        #2;
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
                if (!cpu_run) chk("ready_low_in_write", 32'(rx_ready), 32'd0);
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows the transfer edge, with rx_valid dropped.
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        logic ready_seen;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            ready_seen = rx_ready;
            @(posedge clk);
            ok = ready_seen;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout got=not_accepted exp=accepted byte=%0h", b);
        end
    endtask

    task automatic send_stalled(input logic [7:0] b);
        @(negedge clk);
        send_byte(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        cpu_we   = 1'b0;
        #1;
        chk("rst_rx_ready",   32'(rx_ready),   32'd1);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        chk("rst_cpu_run",    32'(cpu_run),    32'd0);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, and CPU writes ignored before RUN.
        do_reset();
        cpu_we = 1'b1; cpu_addr = 15'h0085; cpu_wdata = 16'h1234;
        #1;
        chk("pre_run_cpu_we_blocked", 32'(mem_we), 32'd0);
        @(negedge clk);
        cpu_we = 1'b0;

        // Two-word load, then CPU pass-through.
        exp_q.push_back('{addr: 7'd0, data: 16'hF201});
        exp_q.push_back('{addr: 7'd1, data: 16'hB100});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hF2); send_byte(8'h01);
        send_byte(8'hB1); send_byte(8'h00);
        #1;
        chk("two_run_during_write", 32'(cpu_run), 32'd0);
        chk("two_we_during_write",  32'(mem_we),  32'd1);
        @(negedge clk); #1;
        chk("two_cpu_run",   32'(cpu_run),   32'd1);
        chk("two_load_done", 32'(load_done), 32'd1);
        chk("two_rx_ready",  32'(rx_ready),  32'd0);
        chk("two_mem0", 32'(mem_model[0]), 32'hF201);
        chk("two_mem1", 32'(mem_model[1]), 32'hB100);
        @(negedge clk);
        exp_q.push_back('{addr: 7'd5, data: 16'h1234});
        cpu_we = 1'b1; cpu_addr = 15'h0085; cpu_wdata = 16'h1234;
        #1;
        chk("pass_mem_we",    32'(mem_we),    32'd1);
        chk("pass_mem_addr",  32'(mem_addr),  32'h05);
        chk("pass_mem_wdata", 32'(mem_wdata), 32'h1234);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("pass_mem5", 32'(mem_model[5]), 32'h1234);

        // Zero-length load goes straight to RUN.
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        #1;
        chk("zero_cpu_run",   32'(cpu_run),   32'd1);
        chk("zero_load_done", 32'(load_done), 32'd1);
        chk("zero_mem_we",    32'(mem_we),    32'd0);

        // Oversized header is rejected and the stream is refused.
        do_reset();
        send_byte(8'h00); send_byte(8'h81);
        #1;
        chk("err_load_error", 32'(load_error), 32'd1);
        chk("err_cpu_run",    32'(cpu_run),    32'd0);
        chk("err_load_done",  32'(load_done),  32'd0);
        rx_valid = 1'b1; rx_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("err_rx_ready_low", 32'(rx_ready), 32'd0);
            chk("err_mem_we_low",   32'(mem_we),   32'd0);
        end
        rx_valid = 1'b0;

        // Maximum legal count (128) accepted, count of 3 with stalls.
        do_reset();
        exp_q.push_back('{addr: 7'd0, data: 16'hA1B2});
        exp_q.push_back('{addr: 7'd1, data: 16'hC3D4});
        exp_q.push_back('{addr: 7'd2, data: 16'hE5F6});
        send_stalled(8'h00); send_stalled(8'h03);
        send_stalled(8'hA1); send_stalled(8'hB2);
        send_stalled(8'hC3); send_stalled(8'hD4);
        send_stalled(8'hE5); send_stalled(8'hF6);
        #1;
        chk("stall_run_during_write", 32'(cpu_run), 32'd0);
        @(negedge clk); #1;
        chk("stall_cpu_run", 32'(cpu_run), 32'd1);
        chk("stall_mem0", 32'(mem_model[0]), 32'hA1B2);
        chk("stall_mem1", 32'(mem_model[1]), 32'hC3D4);
        chk("stall_mem2", 32'(mem_model[2]), 32'hE5F6);

        do_reset();
        send_byte(8'h00); send_byte(8'h80);
        #1;
        chk("max_count_no_error", 32'(load_error), 32'd0);
        chk("max_count_ready",    32'(rx_ready),   32'd1);

        // Reset mid-load, then reload restarts at address 0.
        do_reset();
        exp_q.push_back('{addr: 7'd0, data: 16'hAA55});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'h55);
        @(negedge clk);
        chk("mid_mem0_first", 32'(mem_model[0]), 32'hAA55);
        do_reset();
        exp_q.push_back('{addr: 7'd0, data: 16'hB120});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hB1); send_byte(8'h20);
        #1;
        chk("reload_run_during_write", 32'(cpu_run), 32'd0);
        @(negedge clk); #1;
        chk("reload_cpu_run", 32'(cpu_run), 32'd1);
        chk("reload_mem0", 32'(mem_model[0]), 32'hB120);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
